// File: rtl/hazard_ctrl_unit_pkg.sv
// hazard_pkg: shared types for the pipeline hazard controller.
//   fwd_sel_e  - operand-mux select driven onto ForwardA_E / ForwardB_E
//   hz_state_e - controller state (normal flow, waiting on data memory, timeout)
//   RESULT_LOAD - result-source encoding that marks a load in E
//   reg_hit()  - "producer writes a non-x0 register that the consumer reads"
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RS  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    ERR
  } hz_state_e;

  localparam logic [1:0] RESULT_LOAD = 2'b01;

  // x0 is hardwired to zero, so a write to it never produces a dependency.
  function automatic logic reg_hit(input logic       we,
                                   input logic [4:0] rd,
                                   input logic [4:0] rs);
    return we && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit_fwd_sel.sv
// hazard_fwd_sel: forwarding select for one E-stage source operand.
// Ports:
//   rs_addr_e_i  - source register index read by the instruction in E
//   rd_addr_m_i  - destination of M,  regwrite_m_i - M writes the register file
//   rd_addr_w_i  - destination of W,  regwrite_w_i - W writes the register file
//   fwd_sel_o    - 00 register file, 01 ResultW, 10 ALU_ResultM
// M is the younger producer, so it wins when both M and W match.
module hazard_fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] rs_addr_e_i,
  input  logic [4:0] rd_addr_m_i,
  input  logic       regwrite_m_i,
  input  logic [4:0] rd_addr_w_i,
  input  logic       regwrite_w_i,
  output logic [1:0] fwd_sel_o
);

  fwd_sel_e sel;

  always_comb begin
    sel = FWD_RS;
    if (reg_hit(regwrite_m_i, rd_addr_m_i, rs_addr_e_i)) begin
      sel = FWD_MEM;
    end else if (reg_hit(regwrite_w_i, rd_addr_w_i, rs_addr_e_i)) begin
      sel = FWD_WB;
    end
  end

  assign fwd_sel_o = sel;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: pipeline controller for the 5-stage core.
// Generates the E-stage forwarding selects, F/D/E/M stall enables and D/E/W
// flushes from register addresses and control bits observed in D, E, M and W.
// Ports:
//   i_clk, i_rst_n              - clock (rising edge), async active-low reset
//   i_rs1/2_addr_d              - sources of D (load-use detection)
//   i_rs1/2_addr_e, i_rd_addr_e - sources/destination of E
//   i_regwrite_e, i_resultsrc_e - E writes RF / E result source (01 = load)
//   i_rd_addr_m, i_regwrite_m   - M destination / write enable
//   i_rd_addr_w, i_regwrite_w   - W destination / write enable
//   i_pcsrc_e                   - branch/jump taken in E
//   i_mem_req_m, i_mem_ready    - M-stage memory access / completion
//   o_forward_a/b_e             - operand-mux selects
//   o_stall_f/d/e/m             - hold PC, F/D, D/E, E/M registers
//   o_flush_d/e/w               - bubble F/D, D/E, M/W registers
//   o_mem_err                   - sticky memory-timeout error
//   o_stall_cnt, o_flush_cnt    - saturating stall-cycle / branch-flush counters
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [4:0]       i_rs1_addr_d,
  input  logic [4:0]       i_rs2_addr_d,
  input  logic [4:0]       i_rs1_addr_e,
  input  logic [4:0]       i_rs2_addr_e,
  input  logic [4:0]       i_rd_addr_e,
  input  logic             i_regwrite_e,
  input  logic [1:0]       i_resultsrc_e,
  input  logic [4:0]       i_rd_addr_m,
  input  logic             i_regwrite_m,
  input  logic [4:0]       i_rd_addr_w,
  input  logic             i_regwrite_w,
  input  logic             i_pcsrc_e,
  input  logic             i_mem_req_m,
  input  logic             i_mem_ready,
  output logic [1:0]       o_forward_a_e,
  output logic [1:0]       o_forward_b_e,
  output logic             o_stall_f,
  output logic             o_stall_d,
  output logic             o_stall_e,
  output logic             o_stall_m,
  output logic             o_flush_d,
  output logic             o_flush_e,
  output logic             o_flush_w,
  output logic             o_mem_err,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  localparam int unsigned TMO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  hz_state_e          state_q, state_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic               load_use;
  logic               mem_hold;
  logic               branch_fire;

  // ---------------- forwarding ----------------
  hazard_fwd_sel u_fwd_a (
    .rs_addr_e_i  (i_rs1_addr_e),
    .rd_addr_m_i  (i_rd_addr_m),
    .regwrite_m_i (i_regwrite_m),
    .rd_addr_w_i  (i_rd_addr_w),
    .regwrite_w_i (i_regwrite_w),
    .fwd_sel_o    (o_forward_a_e)
  );

  hazard_fwd_sel u_fwd_b (
    .rs_addr_e_i  (i_rs2_addr_e),
    .rd_addr_m_i  (i_rd_addr_m),
    .regwrite_m_i (i_regwrite_m),
    .rd_addr_w_i  (i_rd_addr_w),
    .regwrite_w_i (i_regwrite_w),
    .fwd_sel_o    (o_forward_b_e)
  );

  // ---------------- load-use detect ----------------
  assign load_use = (i_resultsrc_e == RESULT_LOAD)
                  && (reg_hit(i_regwrite_e, i_rd_addr_e, i_rs1_addr_d)
                   || reg_hit(i_regwrite_e, i_rd_addr_e, i_rs2_addr_d));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= RUN;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
    end
  end

  // ---------------- FSM: next state ----------------
  // tmo counts waiting cycles already spent; the RUN entry cycle is the first,
  // so the access gets exactly MEM_TIMEOUT stalled cycles before ERR.
  always_comb begin
    state_d = state_q;
    tmo_d   = '0;
    unique case (state_q)
      RUN: begin
        if (i_mem_req_m && !i_mem_ready) begin
          state_d = (MEM_TIMEOUT <= 1) ? ERR : MEM_WAIT;
          tmo_d   = TMO_W'(1);
        end
      end
      MEM_WAIT: begin
        if (i_mem_ready) begin
          state_d = RUN;
        end else if (tmo_q >= TMO_W'(MEM_TIMEOUT - 1)) begin
          state_d = ERR;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // The pipeline freezes in the RUN cycle that first sees an unready access,
  // and unfreezes in the ready cycle itself; a branch held in E during the
  // wait therefore flushes in that ready cycle, the first unfrozen one.
  always_comb begin
    o_stall_f   = 1'b0;
    o_stall_d   = 1'b0;
    o_stall_e   = 1'b0;
    o_stall_m   = 1'b0;
    o_flush_d   = 1'b0;
    o_flush_e   = 1'b0;
    o_flush_w   = 1'b0;
    branch_fire = 1'b0;
    mem_hold    = 1'b0;
    unique case (state_q)
      ERR: begin
        o_stall_f = 1'b1;
        o_stall_d = 1'b1;
        o_stall_e = 1'b1;
        o_stall_m = 1'b1;
      end
      default: begin
        if (state_q == MEM_WAIT) begin
          mem_hold = !i_mem_ready;
        end else begin
          mem_hold = i_mem_req_m && !i_mem_ready;
        end
        if (mem_hold) begin
          o_stall_f = 1'b1;
          o_stall_d = 1'b1;
          o_stall_e = 1'b1;
          o_stall_m = 1'b1;
          o_flush_w = 1'b1;
        end else if (i_pcsrc_e) begin
          o_flush_d   = 1'b1;
          o_flush_e   = 1'b1;
          branch_fire = 1'b1;
        end else if (load_use) begin
          o_stall_f = 1'b1;
          o_stall_d = 1'b1;
          o_flush_e = 1'b1;
        end
      end
    endcase
  end

  assign o_mem_err = (state_q == ERR);

  // ---------------- performance counters ----------------
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (o_stall_f && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (branch_fire && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
module tb_hazard_ctrl_unit;

  localparam int unsigned TMO  = 16;
  localparam int unsigned CW   = 8;
  localparam int          MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic          we_e, we_m, we_w, pcsrc, req, ready;
  logic [1:0]    rsrc_e;
  logic [1:0]    fwd_a, fwd_b;
  logic          stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, mem_err;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // behavioural model: outstanding-access bookkeeping and counters
  int m_wait;
  bit m_in_wait;
  bit m_err;
  int m_stall;
  int m_flush;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rs1_addr_d(rs1_d), .i_rs2_addr_d(rs2_d),
    .i_rs1_addr_e(rs1_e), .i_rs2_addr_e(rs2_e), .i_rd_addr_e(rd_e),
    .i_regwrite_e(we_e), .i_resultsrc_e(rsrc_e),
    .i_rd_addr_m(rd_m), .i_regwrite_m(we_m),
    .i_rd_addr_w(rd_w), .i_regwrite_w(we_w),
    .i_pcsrc_e(pcsrc), .i_mem_req_m(req), .i_mem_ready(ready),
    .o_forward_a_e(fwd_a), .o_forward_b_e(fwd_b),
    .o_stall_f(stall_f), .o_stall_d(stall_d), .o_stall_e(stall_e), .o_stall_m(stall_m),
    .o_flush_d(flush_d), .o_flush_e(flush_e), .o_flush_w(flush_w),
    .o_mem_err(mem_err), .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
  );

  typedef struct {
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
    logic       we_e;
    logic [1:0] rsrc_e;
    logic [4:0] rd_m;
    logic       we_m;
    logic [4:0] rd_w;
    logic       we_w;
    logic       pcsrc;
    logic [1:0] e_fa, e_fb;
    logic [3:0] e_ctl;  // {stall_f, stall_d, flush_d, flush_e}
    string      name;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(string nm,
                              logic [4:0] a1d, logic [4:0] a2d, logic [4:0] a1e, logic [4:0] a2e,
                              logic [4:0] rde, logic wee, logic [1:0] rse,
                              logic [4:0] rdm, logic wem, logic [4:0] rdw, logic wew, logic pc,
                              logic [1:0] fa, logic [1:0] fb, logic [3:0] ctl);
    vec_t v;
    v.name = nm; v.rs1_d = a1d; v.rs2_d = a2d; v.rs1_e = a1e; v.rs2_e = a2e;
    v.rd_e = rde; v.we_e = wee; v.rsrc_e = rse; v.rd_m = rdm; v.we_m = wem;
    v.rd_w = rdw; v.we_w = wew; v.pcsrc = pc; v.e_fa = fa; v.e_fb = fb; v.e_ctl = ctl;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (we_m && rd_m != 0 && rd_m == rs) return 2'b10;
    if (we_w && rd_w != 0 && rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic clear_inputs();
    rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0; rd_e = '0; rd_m = '0; rd_w = '0;
    we_e = 1'b0; we_m = 1'b0; we_w = 1'b0; rsrc_e = '0; pcsrc = 1'b0; req = 1'b0; ready = 1'b0;
  endtask

  task automatic model_reset();
    m_wait = 0; m_in_wait = 1'b0; m_err = 1'b0; m_stall = 0; m_flush = 0;
  endtask

  task automatic reset_dut();
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Called just after a falling edge with inputs already driven; checks all
  // outputs against the model, advances the model, returns at the next falling edge.
  task automatic step();
    logic [1:0] efa, efb;
    logic [6:0] ectl;
    bit lu, waiting, sf, sd, se, sm, fd, fe, fw;
    #2;
    efa = ref_fwd(rs1_e);
    efb = ref_fwd(rs2_e);
    lu = we_e && rsrc_e == 2'b01 && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
    {sf, sd, se, sm, fd, fe, fw} = '0;
    waiting = 1'b0;
    if (m_err) begin
      {sf, sd, se, sm} = 4'hf;
    end else begin
      waiting = (req || m_in_wait) && !ready;
      if (waiting)    {sf, sd, se, sm, fw} = 5'h1f;
      else if (pcsrc) {fd, fe} = 2'b11;
      else if (lu)    {sf, sd, fe} = 3'b111;
    end
    ectl = {sf, sd, se, sm, fd, fe, fw};
    chk("fwd_a", 32'(fwd_a), 32'(efa));
    chk("fwd_b", 32'(fwd_b), 32'(efb));
    chk("ctrl", 32'({stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w}), 32'(ectl));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
    chk("mem_err", 32'(mem_err), 32'(m_err));
    if (sf && m_stall < MAXC) m_stall++;
    if (fd && m_flush < MAXC) m_flush++;
    if (!m_err) begin
      if (waiting) begin
        m_wait++;
        m_in_wait = 1'b1;
        if (m_wait >= TMO) m_err = 1'b1;
      end else begin
        m_wait = 0;
        m_in_wait = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    //            name       rs1d rs2d rs1e rs2e rde we rs   rdm wm rdw ww pc  fa     fb     {sf,sd,fd,fe}
    vt.push_back(mk("fwd_m_a",   0, 0,   5,  6,  0, 0, 2'b00, 5, 1, 0, 0, 0, 2'b10, 2'b00, 4'b0000));
    vt.push_back(mk("fwd_m_pri", 0, 0,   1,  5,  0, 0, 2'b00, 5, 1, 5, 1, 0, 2'b00, 2'b10, 4'b0000));
    vt.push_back(mk("fwd_x0",    0, 0,   0,  0,  0, 0, 2'b00, 0, 1, 0, 1, 0, 2'b00, 2'b00, 4'b0000));
    vt.push_back(mk("fwd_w",     0, 0,   7,  7,  0, 0, 2'b00, 3, 1, 7, 1, 0, 2'b01, 2'b01, 4'b0000));
    vt.push_back(mk("fwd_m_off", 0, 0,   7,  2,  0, 0, 2'b00, 7, 0, 7, 1, 0, 2'b01, 2'b00, 4'b0000));
    vt.push_back(mk("lu_rs2",    1, 7,   0,  0,  7, 1, 2'b01, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b1101));
    vt.push_back(mk("lu_gone",   1, 7,   0,  0,  7, 1, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0000));
    vt.push_back(mk("br_over_lu",7, 2,   0,  0,  7, 1, 2'b01, 0, 0, 0, 0, 1, 2'b00, 2'b00, 4'b0011));
    vt.push_back(mk("lu_x0",     0, 3,   0,  0,  0, 1, 2'b01, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0000));
    vt.push_back(mk("lu_nowe",   3, 3,   0,  0,  3, 0, 2'b01, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0000));

    rst_n = 1'b1;
    clear_inputs();
    model_reset();
    #1 rst_n = 1'b0;
    @(negedge clk);

    // reset state
    reset_dut();
    chk("rst_stall_cnt", 32'(stall_cnt), 0);
    chk("rst_flush_cnt", 32'(flush_cnt), 0);
    chk("rst_mem_err", 32'(mem_err), 0);
    step();

    // table vectors
    foreach (vt[i]) begin
      rs1_d = vt[i].rs1_d; rs2_d = vt[i].rs2_d; rs1_e = vt[i].rs1_e; rs2_e = vt[i].rs2_e;
      rd_e = vt[i].rd_e; we_e = vt[i].we_e; rsrc_e = vt[i].rsrc_e;
      rd_m = vt[i].rd_m; we_m = vt[i].we_m; rd_w = vt[i].rd_w; we_w = vt[i].we_w;
      pcsrc = vt[i].pcsrc; req = 1'b0; ready = 1'b0;
      #1;
      chk({vt[i].name, "_fa"}, 32'(fwd_a), 32'(vt[i].e_fa));
      chk({vt[i].name, "_fb"}, 32'(fwd_b), 32'(vt[i].e_fb));
      chk({vt[i].name, "_ctl"}, 32'({stall_f, stall_d, flush_d, flush_e}), 32'(vt[i].e_ctl));
      step();
    end
    chk("flush_cnt_one", 32'(flush_cnt), 1);

    // memory wait, ready on the 4th cycle
    reset_dut();
    req = 1'b1; ready = 1'b0;
    repeat (3) begin
      #1 chk("memwait_stall", 32'({stall_f, stall_d, stall_e, stall_m, flush_w}), 32'h1f);
      step();
    end
    ready = 1'b1;
    #1 chk("memready_nostall", 32'({stall_f, stall_d, stall_e, stall_m, flush_w}), 0);
    step();
    req = 1'b0; ready = 1'b0;
    #1 chk("stall_cnt_3", 32'(stall_cnt), 3);
    step();

    // req with ready in the same cycle: no stall
    req = 1'b1; ready = 1'b1;
    #1 chk("req_ready_nostall", 32'(stall_f), 0);
    step();

    // branch held across a wait flushes once the wait ends
    reset_dut();
    req = 1'b1; ready = 1'b0; pcsrc = 1'b1;
    repeat (2) begin
      #1 chk("br_held", 32'({flush_d, flush_e}), 0);
      step();
    end
    ready = 1'b1;
    #1 chk("br_after_wait", 32'({flush_d, flush_e}), 32'h3);
    step();
    req = 1'b0; ready = 1'b0; pcsrc = 1'b0;
    #1 chk("br_after_cnt", 32'(flush_cnt), 1);
    step();

    // timeout: 16 stalled cycles, then sticky error
    reset_dut();
    req = 1'b1; ready = 1'b0;
    for (int i = 0; i < int'(TMO); i++) begin
      #1 chk("err_low", 32'(mem_err), 0);
      step();
    end
    #1 chk("err_set", 32'(mem_err), 1);
    step();
    req = 1'b0; ready = 1'b1;
    repeat (3) step();
    #1 chk("err_sticky", 32'(mem_err), 1);
    #1 rst_n = 1'b0; req = 1'b0; ready = 1'b0;
    #1 chk("async_rst_err", 32'(mem_err), 0);
    chk("async_rst_stall", 32'(stall_f), 0);
    chk("async_rst_cnt", 32'(stall_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step();

    // reset in the middle of a wait
    req = 1'b1; ready = 1'b0;
    repeat (3) step();
    #2 rst_n = 1'b0; req = 1'b0;
    #1 chk("midwait_rst_stall", 32'({stall_f, stall_m, flush_w}), 0);
    chk("midwait_rst_cnt", 32'(stall_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step();

    // counter saturation
    reset_dut();
    rd_e = 5'd9; we_e = 1'b1; rsrc_e = 2'b01; rs1_d = 5'd9;
    repeat (MAXC + 45) step();
    chk("stall_sat", 32'(stall_cnt), 32'(MAXC));
    pcsrc = 1'b1;
    repeat (MAXC + 5) step();
    chk("flush_sat", 32'(flush_cnt), 32'(MAXC));

    // randomized traffic against the model
    reset_dut();
    for (int n = 0; n < 3000; n++) begin
      rs1_d = 5'($urandom_range(0, 3)); rs2_d = 5'($urandom_range(0, 3));
      rs1_e = 5'($urandom_range(0, 3)); rs2_e = 5'($urandom_range(0, 3));
      rd_e  = 5'($urandom_range(0, 3)); rd_m  = 5'($urandom_range(0, 3));
      rd_w  = 5'($urandom_range(0, 3));
      we_e = 1'($urandom); we_m = 1'($urandom); we_w = 1'($urandom);
      rsrc_e = 2'($urandom_range(0, 3));
      pcsrc = ($urandom_range(0, 3) == 0);
      req   = ($urandom_range(0, 2) == 0) || m_in_wait;
      ready = ($urandom_range(0, 2) == 0);
      step();
      if (m_err && $urandom_range(0, 3) == 0) reset_dut();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
